// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-requester round-robin Wishbone arbiter onto one shared master port
module wb_arbiter (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] p1_wb_adr_i,
   input  logic [31:0] p1_wb_dat_i,
   input  logic        p1_wb_we_i,
   input  logic [3:0]  p1_wb_sel_i,
   input  logic        p1_wb_stb_i,
   input  logic        p1_wb_cyc_i,
   output logic [31:0] p1_wb_dat_o,
   output logic        p1_wb_ack_o,
   output logic        p1_wb_stall_o,
   input  logic [31:0] p2_wb_adr_i,
   input  logic [31:0] p2_wb_dat_i,
   input  logic        p2_wb_we_i,
   input  logic [3:0]  p2_wb_sel_i,
   input  logic        p2_wb_stb_i,
   input  logic        p2_wb_cyc_i,
   output logic [31:0] p2_wb_dat_o,
   output logic        p2_wb_ack_o,
   output logic        p2_wb_stall_o,
   output logic [31:0] m_wb_adr_o,
   output logic [31:0] m_wb_dat_o,
   output logic        m_wb_we_o,
   output logic [3:0]  m_wb_sel_o,
   output logic        m_wb_stb_o,
   output logic        m_wb_cyc_o,
   input  logic [31:0] m_wb_dat_i,
   input  logic        m_wb_ack_i,
   input  logic        m_wb_stall_i
);

   typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_WAIT, S_RESPONSE} state_t;

   state_t      state_q, state_d;
   logic        owner_q;       // 0: port 1 owns the transaction, 1: port 2
   logic        last_grant_q;  // 0: port 1 granted last, 1: port 2
   logic [31:0] adr_q, dat_q;
   logic        we_q;
   logic [3:0]  sel_q;
   logic [31:0] p1_rdata_q, p2_rdata_q;
   logic        p1_valid, p2_valid, p1_grant, p2_grant, owner_cyc, capture;

   assign p1_valid = p1_wb_cyc_i & p1_wb_stb_i;
   assign p2_valid = p2_wb_cyc_i & p2_wb_stb_i;

   // a lone request wins; on a tie the port that was not granted last wins
   assign p1_grant = (state_q == S_IDLE) && p1_valid && (!p2_valid || last_grant_q);
   assign p2_grant = (state_q == S_IDLE) && p2_valid && (!p1_valid || !last_grant_q);

   assign p1_wb_stall_o = rst_i | ~p1_grant;
   assign p2_wb_stall_o = rst_i | ~p2_grant;

   // the owner keeps cyc high for the whole transaction; dropping it aborts
   assign owner_cyc = owner_q ? p2_wb_cyc_i : p1_wb_cyc_i;
   assign capture   = owner_cyc && m_wb_ack_i &&
                      (((state_q == S_REQUEST) && !m_wb_stall_i) || (state_q == S_WAIT));

   assign m_wb_adr_o  = adr_q;
   assign m_wb_dat_o  = dat_q;
   assign m_wb_we_o   = we_q;
   assign m_wb_sel_o  = sel_q;
   assign p1_wb_dat_o = p1_rdata_q;
   assign p2_wb_dat_o = p2_rdata_q;

   // state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // next-state logic: abort takes priority over a memory acknowledge
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (p1_grant || p2_grant) state_d = S_REQUEST;
         end
         S_REQUEST: begin
            if (!owner_cyc)         state_d = S_IDLE;
            else if (!m_wb_stall_i) state_d = m_wb_ack_i ? S_RESPONSE : S_WAIT;
         end
         S_WAIT: begin
            if (!owner_cyc)      state_d = S_IDLE;
            else if (m_wb_ack_i) state_d = S_RESPONSE;
         end
         S_RESPONSE: state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // output decode from the registered state
   always_comb begin
      m_wb_cyc_o  = 1'b0;
      m_wb_stb_o  = 1'b0;
      p1_wb_ack_o = 1'b0;
      p2_wb_ack_o = 1'b0;
      case (state_q)
         S_REQUEST: begin
            m_wb_cyc_o = 1'b1;
            m_wb_stb_o = 1'b1;
         end
         S_WAIT: m_wb_cyc_o = 1'b1;
         S_RESPONSE: begin
            p1_wb_ack_o = ~owner_q;
            p2_wb_ack_o = owner_q;
         end
         default: ;
      endcase
   end

   // latch the winning request and remember who won
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         adr_q        <= '0;
         dat_q        <= '0;
         we_q         <= 1'b0;
         sel_q        <= '0;
      end else if (p1_grant || p2_grant) begin
         owner_q      <= p2_grant;
         last_grant_q <= p2_grant;
         adr_q        <= p2_grant ? p2_wb_adr_i : p1_wb_adr_i;
         dat_q        <= p2_grant ? p2_wb_dat_i : p1_wb_dat_i;
         we_q         <= p2_grant ? p2_wb_we_i  : p1_wb_we_i;
         sel_q        <= p2_grant ? p2_wb_sel_i : p1_wb_sel_i;
      end
   end

   // per-port read data, held until that port's next completed transaction
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         p1_rdata_q <= '0;
         p2_rdata_q <= '0;
      end else if (capture) begin
         if (owner_q) p2_rdata_q <= m_wb_dat_i;
         else         p1_rdata_q <= m_wb_dat_i;
      end
   end

endmodule
